// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
//
// Consumes the uart_done/uart_data byte stream from the UART receiver and
// assembles fixed 5-byte command frames:  HEADER, CMD, ARG, CHK, TAIL.
// A frame whose tail matches and whose CHK equals CMD ^ ARG produces a
// one-cycle cmd_valid strobe with cmd_code/cmd_arg loaded. Rejected frames
// produce a one-cycle frame_err strobe with the reason in err_code.
//
// Ports
//   clock      in   system clock (24 MHz)
//   reset      in   asynchronous reset, active-high
//   uart_done  in   receiver byte-done level (high for several cycles/byte)
//   uart_data  in   received byte, valid while uart_done is high
//   cmd_valid  out  one-cycle pulse: valid frame completed
//   cmd_code   out  CMD byte of the last valid frame
//   cmd_arg    out  ARG byte of the last valid frame
//   frame_err  out  one-cycle pulse: frame rejected
//   err_code   out  last rejection reason: 01 checksum, 10 tail, 11 timeout
//   busy       out  high while a frame is being assembled
// ---------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter logic [7:0]  TAIL        = 8'h55,
    parameter int unsigned TIMEOUT_CYC = 48000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_arg,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [1:0]  ERR_CHK  = 2'b01;
    localparam logic [1:0]  ERR_TAIL = 2'b10;
    localparam logic [1:0]  ERR_TMO  = 2'b11;
    localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ARG,
        GET_CHK,
        GET_TAIL
    } state_t;

    state_t      state;
    logic        done_d;
    logic        byte_stb;
    logic [15:0] tmo_cnt;
    logic [7:0]  cmd_tmp;
    logic [7:0]  arg_tmp;
    logic        chk_ok;

    // uart_done is a level; only its rising edge carries a new byte.
    always_comb begin
        byte_stb = uart_done & ~done_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            tmo_cnt   <= '0;
            cmd_tmp   <= '0;
            arg_tmp   <= '0;
            chk_ok    <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            cmd_arg   <= '0;
            frame_err <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
        end else begin
            done_d    <= uart_done;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (byte_stb) begin
                // A byte arriving on the terminal count still wins.
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (uart_data == HEADER) begin
                            state <= GET_CMD;
                            busy  <= 1'b1;
                        end
                    end
                    GET_CMD: begin
                        cmd_tmp <= uart_data;
                        state   <= GET_ARG;
                    end
                    GET_ARG: begin
                        arg_tmp <= uart_data;
                        state   <= GET_CHK;
                    end
                    GET_CHK: begin
                        chk_ok <= (uart_data == (cmd_tmp ^ arg_tmp));
                        state  <= GET_TAIL;
                    end
                    GET_TAIL: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // Tail mismatch is reported ahead of a checksum mismatch.
                        if (uart_data != TAIL) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_TAIL;
                        end else if (!chk_ok) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHK;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= cmd_tmp;
                            cmd_arg   <= arg_tmp;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if ((state != IDLE) && (tmo_cnt == TERM_CNT)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                tmo_cnt   <= '0;
                frame_err <= 1'b1;
                err_code  <= ERR_TMO;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed frames are driven into uart_cmd_parser; each frame that must end
// in a cmd_valid or frame_err pulse pushes its expected response (kind,
// cmd_code, cmd_arg, err_code and the exact cycle of the pulse) into a
// queue. A monitor on the falling edge pops and compares whenever a pulse
// appears. The timeout is scaled down so the run stays short; all timing
// expectations are expressed relative to TO.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int TO   = 4800;
    localparam int HOLD = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_arg;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    uart_cmd_parser #(
        .HEADER     (8'hAA),
        .TAIL       (8'h55),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .uart_done(uart_done),
        .uart_data(uart_data),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_arg  (cmd_arg),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [7:0] arg;
        logic [1:0] ec;
        int         exp_cyc;
    } exp_t;

    exp_t       q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] m_code      = 8'h00;
    logic [7:0] m_arg       = 8'h00;
    logic [1:0] m_ec        = 2'b00;
    int         last_stb    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_valid(input logic [7:0] c, input logic [7:0] a, input int at);
        exp_t e;
        m_code = c;
        m_arg  = a;
        e = '{is_err: 1'b0, code: c, arg: a, ec: m_ec, exp_cyc: at};
        q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] ec, input int at);
        exp_t e;
        m_ec = ec;
        e = '{is_err: 1'b1, code: m_code, arg: m_arg, ec: ec, exp_cyc: at};
        q.push_back(e);
    endtask

    // Called on a falling edge; the DUT samples the strobe on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int hold);
        uart_done = 1'b1;
        uart_data = b;
        last_stb  = cyc + 1;
        repeat (hold) @(negedge clock);
        uart_done = 1'b0;
        uart_data = 8'h00;
        repeat (8) @(negedge clock);
    endtask

    // kind: 0 no response, 1 cmd_valid, 2 frame_err with code ec
    task automatic send_frame(input logic [7:0] h, input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] k, input logic [7:0] t, input int hold,
                              input int kind, input logic [1:0] ec);
        send_byte(h, hold);
        send_byte(c, hold);
        send_byte(a, hold);
        send_byte(k, hold);
        if (kind == 1) expect_valid(c, a, cyc + 1);
        else if (kind == 2) expect_err(ec, cyc + 1);
        send_byte(t, hold);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_cmd_code"},  32'(cmd_code),  32'd0);
        chk({tag, "_cmd_arg"},   32'(cmd_arg),   32'd0);
        chk({tag, "_err_code"},  32'(err_code),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset === 1'b0 && (cmd_valid === 1'b1 || frame_err === 1'b1)) begin
            exp_t e;
            chk("exclusive_pulses", 32'(cmd_valid & frame_err), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, cmd_valid, frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind",  32'(frame_err), 32'(e.is_err));
                chk("pulse_cycle", 32'(cyc),       32'(e.exp_cyc));
                chk("cmd_code",    32'(cmd_code),  32'(e.code));
                chk("cmd_arg",     32'(cmd_arg),   32'(e.arg));
                chk("err_code",    32'(err_code),  32'(e.ec));
            end
        end
    end

    initial begin
        int t0;
        reset     = 1'b1;
        uart_done = 1'b0;
        uart_data = 8'h00;
        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        // Good frame with long uart_done level per byte.
        send_frame(8'hAA, 8'h12, 8'h34, 8'h26, 8'h55, 1250, 1, 2'b00);

        // Bad checksum, then a good frame.
        send_frame(8'hAA, 8'h12, 8'h34, 8'h27, 8'h55, HOLD, 2, 2'b01);
        send_frame(8'hAA, 8'h01, 8'h02, 8'h03, 8'h55, HOLD, 1, 2'b00);

        // Bad tail (checksum fine).
        send_frame(8'hAA, 8'h12, 8'h34, 8'h26, 8'h54, HOLD, 2, 2'b10);

        // Bad tail and bad checksum together: tail reported.
        send_frame(8'hAA, 8'h12, 8'h34, 8'h00, 8'h54, HOLD, 2, 2'b10);

        // Garbage in IDLE is silently ignored.
        send_byte(8'h00, HOLD);
        send_byte(8'h7F, HOLD);
        send_byte(8'h55, HOLD);
        chk("garbage_busy", 32'(busy), 32'd0);
        send_frame(8'hAA, 8'h05, 8'h06, 8'h03, 8'h55, HOLD, 1, 2'b00);

        // HEADER value in the CMD position is data.
        send_frame(8'hAA, 8'hAA, 8'h00, 8'hAA, 8'h55, HOLD, 1, 2'b00);

        // Timeout after AA 12.
        send_byte(8'hAA, HOLD);
        send_byte(8'h12, HOLD);
        chk("busy_mid_frame", 32'(busy), 32'd1);
        expect_err(2'b11, last_stb + TO);
        repeat (TO + 5) @(negedge clock);
        chk("timeout_busy", 32'(busy), 32'd0);
        chk("timeout_seen", 32'(q.size()), 32'd0);
        send_frame(8'hAA, 8'h21, 8'h43, 8'h62, 8'h55, HOLD, 1, 2'b00);

        // Byte strobe on the terminal-count cycle wins over the timeout.
        send_byte(8'hAA, HOLD);
        send_byte(8'h12, HOLD);
        t0 = last_stb;
        while (cyc + 1 < t0 + TO) @(negedge clock);
        send_byte(8'h34, HOLD);
        chk("boundary_stb_cycle", 32'(last_stb), 32'(t0 + TO));
        chk("boundary_busy", 32'(busy), 32'd1);
        send_byte(8'h26, HOLD);
        expect_valid(8'h12, 8'h34, cyc + 1);
        send_byte(8'h55, HOLD);

        // Reset during GET_ARG discards the partial frame.
        send_byte(8'hAA, HOLD);
        send_byte(8'h12, HOLD);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_idle_outputs("midreset");
        m_code = 8'h00;
        m_arg  = 8'h00;
        m_ec   = 2'b00;
        reset  = 1'b0;
        @(negedge clock);
        send_frame(8'hAA, 8'h0F, 8'hF0, 8'hFF, 8'h55, HOLD, 1, 2'b00);

        repeat (20) @(negedge clock);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net: never hang.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
